riscv_mem_arbiter: RTL and testbench
====================================

RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; BE_WIDTH = DATA_WIDTH/8.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, max consecutive cycles fetch may lose arbitration.
REQ-004 SHALL have parameter TIMEOUT, default 16, max cycles waiting for a memory response.
REQ-005 SHALL have ports, in order:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request
if_addr  in  ADDR_WIDTH  fetch address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  fetch response valid, one cycle
if_rdata  out  DATA_WIDTH  fetch read data
if_err  out  1  fetch timeout, with if_rvalid
d_req  in  1  load/store request
d_we  in  1  1 = store
d_be  in  BE_WIDTH  store byte enables
d_addr  in  ADDR_WIDTH  data address
d_wdata  in  DATA_WIDTH  store data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  data response valid (loads and stores), one cycle
d_rdata  out  DATA_WIDTH  load data
d_err  out  1  data timeout, with d_rvalid
mem_req  out  1  request to shared memory
mem_we  out  1  write strobe
mem_be  out  BE_WIDTH  byte enables
mem_addr  out  ADDR_WIDTH  address
mem_wdata  out  DATA_WIDTH  write data
mem_ready  in  1  memory accepts mem_req this cycle
mem_rvalid  in  1  memory response valid
mem_rdata  in  DATA_WIDTH  memory read data

Function
REQ-006 SHALL implement FSM states IDLE, BUSY_I, BUSY_D; at most one outstanding transaction.
REQ-007 In IDLE, SHALL pick a winner combinationally: data if d_req and starve count < STARVE_LIMIT, otherwise fetch if if_req, otherwise data if d_req.
REQ-008 In IDLE with a winner, SHALL drive mem_req=1 and winner's fields (fetch: mem_we=0, mem_be=all ones, mem_wdata=0); else mem_req and all mem_* outputs SHALL be 0.
REQ-009 SHALL assert winner's gnt in the same cycle only when mem_ready=1, then transition to BUSY_I or BUSY_D at the next edge; mem_ready=0 keeps IDLE and re-arbitrates next cycle.
REQ-010 In BUSY_x, mem_req SHALL be 0 and both gnt SHALL be 0.
REQ-011 On mem_rvalid in BUSY_x, SHALL pass mem_rdata combinationally to owner's rdata with owner's rvalid=1 and err=0, and return to IDLE (no new grant in that cycle).
REQ-012 Non-owner rvalid/err SHALL stay 0; rdata outputs SHALL be 0 when their rvalid is 0.
REQ-013 mem_rvalid in IDLE SHALL be ignored.
REQ-014 Starve counter SHALL increment (saturating at STARVE_LIMIT) each IDLE cycle with if_req=1 and fetch not granted, and clear on if_gnt or if_req=0.
REQ-015 Timeout counter SHALL clear on entering BUSY_x and increment each BUSY_x cycle without mem_rvalid; at TIMEOUT-1 without mem_rvalid, SHALL assert owner's rvalid=1, err=1, rdata=0 and return to IDLE.
REQ-016 After a timeout, a late mem_rvalid SHALL be ignored while in IDLE.

Reset
REQ-017 rst_n low SHALL immediately force IDLE, clear both counters, and drive every output to 0, including mid-transaction; the interrupted transaction produces no response.

Verification
REQ-018 Fetch only, addr 0x100, mem_ready=1, rvalid 2 cycles later with 0x00000013 -> if_gnt 1 cycle, if_rvalid with if_rdata=0x00000013, d_* outputs 0.
REQ-019 Simultaneous if_req and d_req (store, be=4'b0011, addr 0x200, wdata 0xDEADBEEF) -> data granted first with mem_we=1, mem_be=4'b0011; fetch granted on next IDLE cycle.
REQ-020 d_req held continuously with if_req -> fetch granted no later than its 5th IDLE losing cycle (STARVE_LIMIT=4).
REQ-021 Grant, then no mem_rvalid -> owner rvalid=1, err=1 in 16th BUSY cycle; late mem_rvalid ignored.
REQ-022 rst_n low while in BUSY_D -> all outputs 0 at once; after release, a stray mem_rvalid produces no d_rvalid.

Source files
------------

// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - fetch/data arbiter onto one shared memory port with starvation guard and response timeout
module riscv_mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16,
  localparam int BE_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [BE_WIDTH-1:0]   d_be,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [BE_WIDTH-1:0]   mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          pick_i, pick_d, busy, tmo_hit, done, grant;
  logic          own_i, own_d;

  always_comb begin
    pick_i = 1'b0;
    pick_d = 1'b0;
    if (state_q == IDLE) begin
      if (d_req && (starve_q < STARVE_MAX)) pick_d = 1'b1;
      else if (if_req)                      pick_i = 1'b1;
      else if (d_req)                       pick_d = 1'b1;
    end
  end

  assign busy    = (state_q != IDLE);
  assign tmo_hit = busy && !mem_rvalid && (tmo_q == TMO_MAX);
  assign done    = busy && (mem_rvalid || tmo_hit);
  assign grant   = (pick_i || pick_d) && mem_ready;
  assign own_i   = rst_n && done && (state_q == BUSY_I);
  assign own_d   = rst_n && done && (state_q == BUSY_D);

  // Every output is gated by rst_n so reset silences the port without waiting for a clock.
  assign mem_req   = rst_n && (pick_i || pick_d);
  assign mem_we    = rst_n && pick_d && d_we;
  assign mem_be    = !rst_n ? '0 : pick_d ? d_be    : pick_i ? '1      : '0;
  assign mem_addr  = !rst_n ? '0 : pick_d ? d_addr  : pick_i ? if_addr : '0;
  assign mem_wdata = (rst_n && pick_d) ? d_wdata : '0;

  assign if_gnt    = rst_n && pick_i && mem_ready;
  assign d_gnt     = rst_n && pick_d && mem_ready;
  assign if_rvalid = own_i;
  assign d_rvalid  = own_d;
  assign if_err    = own_i && !mem_rvalid;
  assign d_err     = own_d && !mem_rvalid;
  assign if_rdata  = (own_i && mem_rvalid) ? mem_rdata : '0;
  assign d_rdata   = (own_d && mem_rvalid) ? mem_rdata : '0;

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    starve_d = starve_q;
    if (!busy) begin
      if (grant) begin
        state_d = pick_i ? BUSY_I : BUSY_D;
        tmo_d   = '0;
      end
    end else if (done) begin
      state_d = IDLE;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end
    // Fetch losing an IDLE cycle ages it; waiting in BUSY neither ages nor forgives it.
    if (!if_req || if_gnt) starve_d = '0;
    else if (!busy && (starve_q != STARVE_MAX)) starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      tmo_q    <= tmo_d;
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb/tb_riscv_mem_arbiter.sv - directed and randomized check of riscv_mem_arbiter against a transaction-level model
module tb_riscv_mem_arbiter;
  localparam int AW = 32, DW = 32, BW = 4, SL = 4, TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic if_req, d_req, d_we, mem_ready, mem_rvalid;
  logic [AW-1:0] if_addr, d_addr;
  logic [BW-1:0] d_be;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, mem_req, mem_we;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;

  logic e_if_gnt, e_if_rvalid, e_if_err, e_d_gnt, e_d_rvalid, e_d_err, e_mem_req, e_mem_we;
  logic [DW-1:0] e_if_rdata, e_d_rdata, e_mem_wdata;
  logic [BW-1:0] e_mem_be;
  logic [AW-1:0] e_mem_addr;

  int n_assert = 0, n_fail = 0;
  int m_owner = 0, m_wait = 0, m_starve = 0;   // owner: 0 none, 1 fetch, 2 data

  always #5 clk = ~clk;

  riscv_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic quiet();
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  // One clock: predict outputs from the model, compare, clock, then advance the model.
  task automatic step();
    int win;
    bit resp;
    win = 0; resp = 0;
    #1;
    {e_if_gnt, e_if_rvalid, e_if_err, e_d_gnt, e_d_rvalid, e_d_err, e_mem_req, e_mem_we} = '0;
    e_if_rdata = '0; e_d_rdata = '0; e_mem_wdata = '0; e_mem_be = '0; e_mem_addr = '0;
    if (rst_n) begin
      if (m_owner == 0) begin
        if (d_req && (m_starve < SL || !if_req)) win = 2;
        else if (if_req) win = 1;
        if (win == 1) begin
          e_mem_req = 1; e_mem_be = '1; e_mem_addr = if_addr; e_if_gnt = mem_ready;
        end else if (win == 2) begin
          e_mem_req = 1; e_mem_we = d_we; e_mem_be = d_be; e_mem_addr = d_addr;
          e_mem_wdata = d_wdata; e_d_gnt = mem_ready;
        end
      end else begin
        resp = mem_rvalid || (m_wait == TO - 1);
        if (resp && m_owner == 1) begin
          e_if_rvalid = 1; e_if_err = !mem_rvalid; e_if_rdata = mem_rvalid ? mem_rdata : '0;
        end
        if (resp && m_owner == 2) begin
          e_d_rvalid = 1; e_d_err = !mem_rvalid; e_d_rdata = mem_rvalid ? mem_rdata : '0;
        end
      end
    end
    chk("if_gnt", if_gnt, e_if_gnt);       chk("if_rvalid", if_rvalid, e_if_rvalid);
    chk("if_err", if_err, e_if_err);       chk("if_rdata", if_rdata, e_if_rdata);
    chk("d_gnt", d_gnt, e_d_gnt);          chk("d_rvalid", d_rvalid, e_d_rvalid);
    chk("d_err", d_err, e_d_err);          chk("d_rdata", d_rdata, e_d_rdata);
    chk("mem_req", mem_req, e_mem_req);    chk("mem_we", mem_we, e_mem_we);
    chk("mem_be", mem_be, e_mem_be);       chk("mem_addr", mem_addr, e_mem_addr);
    chk("mem_wdata", mem_wdata, e_mem_wdata);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_owner = 0; m_wait = 0; m_starve = 0;
    end else if (m_owner == 0) begin
      if (win != 0 && mem_ready) begin m_owner = win; m_wait = 0; end
      if (!if_req || e_if_gnt) m_starve = 0;
      else if (m_starve < SL) m_starve++;
    end else begin
      if (resp) m_owner = 0; else m_wait++;
      if (!if_req) m_starve = 0;
    end
  endtask

  initial begin
    int losses, cnt;
    rst_n = 0; quiet(); if_req = 1; d_req = 1; mem_ready = 1;
    #1;
    chk("reset_mem_req", mem_req, 0);
    chk("reset_if_gnt", if_gnt, 0);
    step(); step();
    rst_n = 1; quiet(); step();

    // Single fetch, two-cycle memory latency
    if_req = 1; if_addr = 32'h100; mem_ready = 1;
    #1; chk("f_gnt", if_gnt, 1);
    step();
    if_req = 0; if_addr = '0; mem_ready = 0; step();
    mem_rvalid = 1; mem_rdata = 32'h13;
    #1; chk("f_rdata", if_rdata, 32'h13); chk("f_no_d", d_rvalid, 0);
    step();
    quiet(); step();

    // Simultaneous store and fetch: data first, fetch next IDLE cycle
    if_req = 1; if_addr = 32'h104; d_req = 1; d_we = 1; d_be = 4'b0011;
    d_addr = 32'h200; d_wdata = 32'hDEADBEEF; mem_ready = 1;
    #1; chk("s_d_first", d_gnt, 1); chk("s_we", mem_we, 1); chk("s_be", mem_be, 4'b0011);
    chk("s_if_wait", if_gnt, 0);
    step();
    d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0; step();
    mem_rvalid = 1; step();
    mem_rvalid = 0;
    #1; chk("s_f_next", if_gnt, 1);
    step();
    mem_rvalid = 1; mem_rdata = 32'h55; step();
    quiet(); step(); step();

    // Continuous data pressure: fetch wins after STARVE_LIMIT losses
    if_req = 1; if_addr = 32'h300; d_req = 1; d_addr = 32'h400; d_be = 4'hF; mem_ready = 1;
    losses = 0; cnt = 0;
    while (cnt < 60) begin
      mem_rvalid = (m_owner != 0); mem_rdata = $urandom;
      #1;
      if (if_gnt) break;
      if (d_gnt) losses++;
      step(); cnt++;
    end
    chk("starve_losses", losses, SL);
    chk("starve_won", if_gnt, 1);
    step();
    quiet(); mem_rvalid = 1; step();
    mem_rvalid = 0; step();

    // Timeout on a load, then a late response is ignored
    d_req = 1; d_addr = 32'h500; d_be = 4'hF; mem_ready = 1;
    step();
    quiet(); cnt = 0;
    while (cnt < 40) begin
      cnt++;
      #1;
      if (d_rvalid) break;
      step();
    end
    chk("tmo_cycle", cnt, TO);
    chk("tmo_err", d_err, 1);
    step();
    mem_rvalid = 1; mem_rdata = 32'hBAD;
    #1; chk("late_ignored", d_rvalid, 0);
    step();
    quiet(); step();

    // Reset in the middle of a data transaction
    d_req = 1; d_addr = 32'h600; d_be = 4'hF; mem_ready = 1; step();
    quiet(); step();
    rst_n = 0; mem_rvalid = 1; d_req = 1; if_req = 1; mem_ready = 1;
    #1; chk("rst_d_rvalid", d_rvalid, 0); chk("rst_mem_req", mem_req, 0);
    step();
    rst_n = 1; quiet(); mem_rvalid = 1; mem_rdata = 32'h77;
    #1; chk("rst_stray", d_rvalid, 0);
    step();
    quiet(); step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n      = !(rst_n && ($urandom_range(0, 399) == 0));
      if (!rst_n && $urandom_range(0, 1)) rst_n = 1;
      if_req     = $urandom_range(0, 2) != 0;
      if_addr    = $urandom;
      d_req      = $urandom_range(0, 2) != 0;
      d_we       = $urandom;
      d_be       = $urandom;
      d_addr     = $urandom;
      d_wdata    = $urandom;
      mem_ready  = $urandom_range(0, 3) != 0;
      mem_rvalid = $urandom_range(0, 5) == 0;
      mem_rdata  = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
